des_key_schedule_ctrl: RTL and testbench
========================================

Name: des_key_schedule_ctrl

Overview:
Sequences the DES key schedule for one 16-round pass. It takes the C/D halves produced by the PC-1 key-generation stage and applies the per-round circular shifts and PC-2. Subkeys K1..K16 are presented to the round datapath over a valid/ready handshake. Each pass runs in encrypt order (K1..K16) or decrypt order (K16..K1), so the Triple-DES top can run E-D-E passes back to back.

Parameters:
NUM_ROUNDS, 16, rounds per pass; fixed by DES, kept for bench shortening only.

Ports:
CLK  in  1  system clock, rising edge
RESET_BAR  in  1  asynchronous active-low reset
START  in  1  begin a pass; sampled in IDLE only
DECRYPT  in  1  pass direction, sampled with START: 0 = K1..K16, 1 = K16..K1
ABORT  in  1  synchronous cancel of the current pass
C_IN  in  28  PC-1 output bits 1..28; C_IN[i] = FIPS bit i
D_IN  in  28  PC-1 output bits 29..56; D_IN[i] = FIPS bit 28+i
SUBKEY  out  48  current subkey; SUBKEY[i] = FIPS PC-2 output bit i
SUBKEY_VALID  out  1  SUBKEY holds a valid round key
SUBKEY_READY  in  1  consumer accepts SUBKEY when high with VALID
ROUND_NUM  out  5  round index 1..16 of the presented key (0 in IDLE)
BUSY  out  1  pass in progress
DONE  out  1  one-cycle pulse after round 16 is accepted

Behaviour:
- Reset (RESET_BAR low, asynchronous): state IDLE; C/D registers, SUBKEY, ROUND_NUM = 0; SUBKEY_VALID, BUSY, DONE = 0. Takes effect mid-pass; any partial pass is discarded.
- Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Left rotate by 1: new[i] = old[i+1], new[28] = old[1]. Right rotate by 1 is the inverse. C and D rotate independently.
- PC-2 is the FIPS 46-3 table over CD[1..56], where CD[i] = C[i] for i ≤ 28, else D[i-28]. It is purely combinational off the rotated value.
- FSM states:
  - IDLE: START=1 (ABORT=0) at edge t:
    - encrypt: C/D ← rotl(C_IN/D_IN, s[1]).
    - decrypt: C/D ← C_IN/D_IN unrotated.
    - SUBKEY ← PC2 of the new C/D; ROUND_NUM ← 1; SUBKEY_VALID, BUSY ← 1; go to ACTIVE.
    - Latency: first subkey is valid in the cycle after edge t.
  - ACTIVE:
    - SUBKEY, ROUND_NUM and C/D are held stable while VALID=1 and READY=0.
    - On handshake with ROUND_NUM = r < 16: ROUND_NUM ← r+1; C/D ← rotl(C/D, s[r+1]) when encrypting, or rotr(C/D, s[17-r]) when decrypting; SUBKEY ← PC2 of the new C/D; VALID stays 1.
    - Back-to-back throughput is 1 subkey per cycle.
    - On handshake with r = 16: VALID, BUSY ← 0; ROUND_NUM ← 0; DONE ← 1 for one cycle; go to IDLE.
    - The C/D registers then equal the loaded C_IN/D_IN (total rotation 28).
- DECRYPT is latched at START; later changes have no effect until the next pass.
- START while BUSY is ignored (no queueing). START in the same cycle as DONE is ignored.
- ABORT=1 in ACTIVE: next edge gives IDLE, VALID/BUSY/ROUND_NUM = 0, no DONE. ABORT has priority over a simultaneous handshake. ABORT in IDLE has priority over START.
- All outputs are registered.

Decomposition:
- Shared package des_pkg:
  - shift table s[1..16]
  - PC-2 index table
  - state encoding IDLE/ACTIVE
  - ROUND_NUM width constant
- One sub-module, des_pc2: combinational 56→48 permutation, reusable by other key paths.
- The rotate logic stays inline in the controller.

Test Plan:
- FIPS vector: C_IN=F0CCAAF, D_IN=556678F (FIPS bit 1 = leftmost), DECRYPT=0, READY held 1 -> ROUND_NUM 1 gives SUBKEY 1B02EFFC7072; ROUND_NUM 16 gives CB3D8B0E17F5; DONE pulses 17 cycles after START; final C/D equals C_IN/D_IN.
- Same key, DECRYPT=1 -> first SUBKEY CB3D8B0E17F5, last 1B02EFFC7072; the 16 keys are exactly the encrypt sequence reversed.
- Backpressure: READY toggled randomly, with a 5-cycle stall in round 7 -> SUBKEY and ROUND_NUM (7) stable throughout the stall; exactly 16 handshakes; no key skipped or duplicated.
- ABORT asserted in round 9 with READY=1 in the same cycle -> next cycle VALID=0, BUSY=0, ROUND_NUM=0, DONE never pulses. A following START produces K1 correctly.
- START pulsed during round 4 and in the DONE cycle -> both ignored; the pass completes normally and no second pass starts.
- RESET_BAR dropped asynchronously mid-round 12 -> all outputs 0 immediately. After release, a START gives the correct K1 = 1B02EFFC7072.

Source files
------------

// File: rtl/des_pkg.sv
// DES key schedule shared constants: shift table, PC-2 indices, FSM encoding.
// Vectors are MSB-first: FIPS bit 1 sits in the highest index.
package des_pkg;

  localparam int ROUND_W = 5;
  localparam int HALF_W  = 28;
  localparam int KEY_W   = 48;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [1:0] SHIFT_TBL [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [5:0] PC2_TBL [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

endpackage

// File: rtl/des_pc2.sv
// DES PC-2: combinational 56-to-48 bit selection.
// FIPS bit k of cd lives at cd[56-k]; key bit j at key[48-j].
module des_pc2
  import des_pkg::*;
(
  input  logic [2*HALF_W-1:0] cd,
  output logic [KEY_W-1:0]    key
);

  for (genvar j = 0; j < KEY_W; j++) begin : g_bit
    localparam int SRC = 2 * HALF_W - int'(PC2_TBL[j]);
    assign key[KEY_W-1-j] = cd[SRC];
  end

endmodule

// File: rtl/des_key_schedule_ctrl.sv
// DES key schedule sequencer: rotates C/D per round and streams
// PC-2 subkeys in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic               CLK,
  input  logic               RESET_BAR,
  input  logic               START,
  input  logic               DECRYPT,
  input  logic               ABORT,
  input  logic [HALF_W-1:0]  C_IN,
  input  logic [HALF_W-1:0]  D_IN,
  output logic [KEY_W-1:0]   SUBKEY,
  output logic               SUBKEY_VALID,
  input  logic               SUBKEY_READY,
  output logic [ROUND_W-1:0] ROUND_NUM,
  output logic               BUSY,
  output logic               DONE
);

  localparam logic [ROUND_W-1:0] LAST =
    ROUND_W'(NUM_ROUNDS);

  function automatic logic [HALF_W-1:0] rotl(
    input logic [HALF_W-1:0] x,
    input logic [1:0]        n
  );
    return (n == 2'd2) ? {x[25:0], x[27:26]}
                       : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(
    input logic [HALF_W-1:0] x,
    input logic [1:0]        n
  );
    return (n == 2'd2) ? {x[1:0], x[27:2]}
                       : {x[0], x[27:1]};
  endfunction

  state_t              state_q, state_n;
  logic [HALF_W-1:0]   c_q, c_n;
  logic [HALF_W-1:0]   d_q, d_n;
  logic                dec_q, dec_n;
  logic [KEY_W-1:0]    key_q, key_n;
  logic [ROUND_W-1:0]  round_q, round_n;
  logic                valid_q, valid_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                load;
  logic [KEY_W-1:0]    pc2_key;
  logic [3:0]          enc_idx;
  logic [3:0]          dec_idx;

  // Encrypt uses s[r+1], decrypt s[17-r]; table is zero-based.
  assign enc_idx = round_q[3:0];
  assign dec_idx = 4'd0 - round_q[3:0];

  always_comb begin
    state_n = state_q;
    c_n     = c_q;
    d_n     = d_q;
    dec_n   = dec_q;
    round_n = round_q;
    valid_n = valid_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START && !ABORT && !done_q) begin
          dec_n   = DECRYPT;
          c_n     = DECRYPT ? C_IN
                            : rotl(C_IN, SHIFT_TBL[0]);
          d_n     = DECRYPT ? D_IN
                            : rotl(D_IN, SHIFT_TBL[0]);
          round_n = ROUND_W'(1);
          valid_n = 1'b1;
          busy_n  = 1'b1;
          load    = 1'b1;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ABORT) begin
          state_n = IDLE;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          round_n = '0;
        end else if (SUBKEY_READY) begin
          if (round_q == LAST) begin
            state_n = IDLE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            round_n = '0;
            done_n  = 1'b1;
            // Decrypt still owes s[1] to close the 28-bit loop.
            if (dec_q) begin
              c_n = rotr(c_q, SHIFT_TBL[0]);
              d_n = rotr(d_q, SHIFT_TBL[0]);
            end
          end else begin
            round_n = round_q + ROUND_W'(1);
            c_n = dec_q ? rotr(c_q, SHIFT_TBL[dec_idx])
                        : rotl(c_q, SHIFT_TBL[enc_idx]);
            d_n = dec_q ? rotr(d_q, SHIFT_TBL[dec_idx])
                        : rotl(d_q, SHIFT_TBL[enc_idx]);
            load = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  des_pc2 u_pc2 (
    .cd  ({c_n, d_n}),
    .key (pc2_key)
  );

  assign key_n = load ? pc2_key : key_q;

  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      c_q     <= c_n;
      d_q     <= d_n;
      dec_q   <= dec_n;
      key_q   <= key_n;
      round_q <= round_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign SUBKEY       = key_q;
  assign SUBKEY_VALID = valid_q;
  assign ROUND_NUM    = round_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// Scoreboard bench for des_key_schedule_ctrl using the FIPS 46-3
// worked key 133457799BBCDFF1 and its published subkeys.
module tb_des_key_schedule_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_BAR = 1'b0;
  logic        START = 1'b0;
  logic        DECRYPT = 1'b0;
  logic        ABORT = 1'b0;
  logic        SUBKEY_READY = 1'b0;
  logic [27:0] C_IN = 28'hF0CCAAF;
  logic [27:0] D_IN = 28'h556678F;
  logic [47:0] SUBKEY;
  logic        SUBKEY_VALID;
  logic [4:0]  ROUND_NUM;
  logic        BUSY;
  logic        DONE;

  des_key_schedule_ctrl #(.NUM_ROUNDS(16)) dut (
    .CLK          (CLK),
    .RESET_BAR    (RESET_BAR),
    .START        (START),
    .DECRYPT      (DECRYPT),
    .ABORT        (ABORT),
    .C_IN         (C_IN),
    .D_IN         (D_IN),
    .SUBKEY       (SUBKEY),
    .SUBKEY_VALID (SUBKEY_VALID),
    .SUBKEY_READY (SUBKEY_READY),
    .ROUND_NUM    (ROUND_NUM),
    .BUSY         (BUSY),
    .DONE         (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  r;
    logic [47:0] k;
  } exp_t;

  exp_t        sbq [$];
  logic [47:0] kt [1:16];
  int          n_chk = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RESET_BAR && DONE) done_cnt++;
    if (RESET_BAR && SUBKEY_VALID && SUBKEY_READY
        && !ABORT) begin
      hs_cnt++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra: round %0d key %0h, expected none",
                 ROUND_NUM, SUBKEY);
      end else begin
        e = sbq.pop_front();
        chk("sb_round", 64'(ROUND_NUM), 64'(e.r));
        chk("sb_key", 64'(SUBKEY), 64'(e.k));
      end
    end
  end

  task automatic push_pass(input logic dec);
    exp_t e;
    for (int r = 1; r <= 16; r++) begin
      e.r = 5'(r);
      e.k = dec ? kt[17-r] : kt[r];
      sbq.push_back(e);
    end
  endtask

  task automatic start_pass(input logic dec);
    push_pass(dec);
    @(posedge CLK); #1;
    START = 1'b1;
    DECRYPT = dec;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("k1_valid", 64'(SUBKEY_VALID), 64'd1);
    chk("k1_round", 64'(ROUND_NUM), 64'd1);
  endtask

  task automatic wait_done(input string nm,
                           input int budget,
                           output int cyc);
    cyc = 0;
    while (!DONE && cyc < budget) begin
      @(posedge CLK); #1;
      cyc++;
    end
    if (!DONE) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: DONE=0 after %0d cycles, expected 1",
               nm, budget);
    end else begin
      chk({nm, "_busy"}, 64'(BUSY), 64'd0);
      chk({nm, "_valid"}, 64'(SUBKEY_VALID), 64'd0);
      chk({nm, "_round"}, 64'(ROUND_NUM), 64'd0);
      @(posedge CLK); #1;
      chk({nm, "_pulse"}, 64'(DONE), 64'd0);
    end
    chk({nm, "_drained"}, 64'(sbq.size()), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int cyc;
    int hs0;
    int d0;
    logic stalled;
    logic pulsed;

    kt[1]  = 48'h1B02EFFC7072;
    kt[2]  = 48'h79AED9DBC9E5;
    kt[3]  = 48'h55FC8A42CF99;
    kt[4]  = 48'h72ADD6DB351D;
    kt[5]  = 48'h7CEC07EB53A8;
    kt[6]  = 48'h63A53E507B2F;
    kt[7]  = 48'hEC84B7F618BC;
    kt[8]  = 48'hF78A3AC13BFB;
    kt[9]  = 48'hE0DBEBEDE781;
    kt[10] = 48'hB1F347BA464F;
    kt[11] = 48'h215FD3DED386;
    kt[12] = 48'h7571F59467E9;
    kt[13] = 48'h97C5D1FABA41;
    kt[14] = 48'h5F43B7F2E73A;
    kt[15] = 48'hBF918D3D3F0A;
    kt[16] = 48'hCB3D8B0E17F5;

    #3;
    chk("rst_valid", 64'(SUBKEY_VALID), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_round", 64'(ROUND_NUM), 64'd0);
    chk("rst_key", 64'(SUBKEY), 64'd0);
    #20 RESET_BAR = 1'b1;

    // Encrypt, READY high, DONE latency from START.
    SUBKEY_READY = 1'b1;
    hs0 = hs_cnt;
    push_pass(1'b0);
    @(posedge CLK); #1;
    START = 1'b1;
    DECRYPT = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done("enc", 40, cyc);
    chk("enc_latency", 64'(cyc + 1), 64'd17);
    chk("enc_hs", 64'(hs_cnt - hs0), 64'd16);
    chk("enc_final_c", 64'(dut.c_q), 64'(C_IN));
    chk("enc_final_d", 64'(dut.d_q), 64'(D_IN));

    // Decrypt; DECRYPT flips mid-pass and must be ignored.
    hs0 = hs_cnt;
    start_pass(1'b1);
    chk("dec_k1", 64'(SUBKEY), 64'(kt[16]));
    DECRYPT = 1'b0;
    wait_done("dec", 40, cyc);
    chk("dec_hs", 64'(hs_cnt - hs0), 64'd16);
    chk("dec_final_c", 64'(dut.c_q), 64'(C_IN));
    chk("dec_final_d", 64'(dut.d_q), 64'(D_IN));

    // Random backpressure with a 5-cycle stall in round 7.
    hs0 = hs_cnt;
    SUBKEY_READY = 1'b0;
    start_pass(1'b0);
    stalled = 1'b0;
    cyc = 0;
    while (!DONE && cyc < 300) begin
      if (ROUND_NUM == 5'd7 && !stalled) begin
        stalled = 1'b1;
        SUBKEY_READY = 1'b0;
        repeat (5) begin
          @(posedge CLK); #1;
          chk("stall_round", 64'(ROUND_NUM), 64'd7);
          chk("stall_key", 64'(SUBKEY), 64'(kt[7]));
          chk("stall_valid", 64'(SUBKEY_VALID), 64'd1);
        end
      end
      SUBKEY_READY = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      cyc++;
    end
    chk("stall_seen", 64'(stalled), 64'd1);
    wait_done("bp", 1, cyc);
    chk("bp_hs", 64'(hs_cnt - hs0), 64'd16);

    // ABORT in round 9 together with READY.
    SUBKEY_READY = 1'b1;
    start_pass(1'b0);
    cyc = 0;
    while (ROUND_NUM != 5'd9 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("abort_at_r9", 64'(ROUND_NUM), 64'd9);
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    chk("abort_valid", 64'(SUBKEY_VALID), 64'd0);
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_round", 64'(ROUND_NUM), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    sbq.delete();
    d0 = done_cnt;
    repeat (20) @(posedge CLK);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    start_pass(1'b0);
    chk("abort_k1", 64'(SUBKEY), 64'(kt[1]));
    wait_done("post_abort", 40, cyc);

    // START in round 4 and in the DONE cycle are both ignored.
    start_pass(1'b0);
    pulsed = 1'b0;
    cyc = 0;
    while (!DONE && cyc < 40) begin
      START = (ROUND_NUM == 5'd4) && !pulsed;
      if (START) pulsed = 1'b1;
      @(posedge CLK); #1;
      cyc++;
    end
    START = 1'b0;
    chk("ign_pulsed", 64'(pulsed), 64'd1);
    chk("ign_done_seen", 64'(DONE), 64'd1);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("ign_valid", 64'(SUBKEY_VALID), 64'd0);
    chk("ign_busy", 64'(BUSY), 64'd0);
    repeat (5) @(posedge CLK);
    #1;
    chk("ign_idle_busy", 64'(BUSY), 64'd0);
    chk("ign_drained", 64'(sbq.size()), 64'd0);

    // Asynchronous reset in round 12.
    start_pass(1'b0);
    cyc = 0;
    while (ROUND_NUM != 5'd12 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("rst_at_r12", 64'(ROUND_NUM), 64'd12);
    #2 RESET_BAR = 1'b0;
    #1;
    chk("arst_valid", 64'(SUBKEY_VALID), 64'd0);
    chk("arst_busy", 64'(BUSY), 64'd0);
    chk("arst_round", 64'(ROUND_NUM), 64'd0);
    chk("arst_key", 64'(SUBKEY), 64'd0);
    chk("arst_done", 64'(DONE), 64'd0);
    sbq.delete();
    repeat (2) @(negedge CLK);
    RESET_BAR = 1'b1;
    start_pass(1'b0);
    chk("arst_k1", 64'(SUBKEY), 64'(kt[1]));
    wait_done("post_rst", 40, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
